i2c_read_responder: RTL

I2C_READ_RESPONDER -- requirements
Module: i2c_read_responder

---
 rtl/i2c_read_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/i2c_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_read_responder
// Brief    : I2C target read path: address match, register pointer, byte fetch.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_read_responder #(
   parameter logic [6:0] DEVICE_ADDR = 7'h40,
   parameter int         ADDR_BITS   = 8,
   parameter int         DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sleep,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   input  logic                 tx_ready,
   input  logic                 ack_valid,
   input  logic                 master_ack,
   input  logic [DATA_BITS-1:0] bus_rdata,
   output logic [ADDR_BITS-1:0] bus_addr,
   output logic                 bus_r_en,
   output logic                 addr_ack,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   output logic                 read_done
);

   localparam logic [3:0] c_IDLE     = 4'd0;
   localparam logic [3:0] c_ADDR     = 4'd1;
   localparam logic [3:0] c_REG      = 4'd2;
   localparam logic [3:0] c_WAIT_RS  = 4'd3;
   localparam logic [3:0] c_FETCH    = 4'd4;
   localparam logic [3:0] c_CAPTURE  = 4'd5;
   localparam logic [3:0] c_PRESENT  = 4'd6;
   localparam logic [3:0] c_WAIT_ACK = 4'd7;
   localparam logic [3:0] c_DRAIN    = 4'd8;

   logic [3:0]           r_state;
   logic [ADDR_BITS-1:0] r_ptr;
   logic                 w_match;
   logic                 w_busy;
   logic [ADDR_BITS-1:0] w_ptr_inc;

   assign w_match   = (rx_data[7:1] == DEVICE_ADDR) && !sleep;
   assign w_busy    = (r_state == c_FETCH) || (r_state == c_CAPTURE) ||
                      (r_state == c_PRESENT) || (r_state == c_WAIT_ACK);
   assign w_ptr_inc = r_ptr + ADDR_BITS'(1);

   // The read strobe is issued on entry to FETCH so it is high during the
   // FETCH cycle; bus_rdata then lands in CAPTURE, giving tx_valid two cycles
   // after bus_r_en.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_IDLE;
         r_ptr     <= '0;
         bus_addr  <= '0;
         bus_r_en  <= 1'b0;
         addr_ack  <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
         read_done <= 1'b0;
      end else begin
         bus_r_en <= 1'b0;
         addr_ack <= 1'b0;
         if (stop) begin
            r_state  <= c_IDLE;
            tx_valid <= 1'b0;
         end else if (start) begin
            r_state   <= c_ADDR;
            tx_valid  <= 1'b0;
            read_done <= 1'b0;
         end else if (sleep && w_busy) begin
            r_state  <= c_DRAIN;
            tx_valid <= 1'b0;
         end else begin
            case (r_state)
               c_IDLE, c_WAIT_RS, c_DRAIN: begin
               end
               c_ADDR: begin
                  if (rx_valid) begin
                     if (!w_match) begin
                        r_state <= c_DRAIN;
                     end else begin
                        addr_ack <= 1'b1;
                        if (rx_data[0]) begin
                           r_state  <= c_FETCH;
                           bus_r_en <= 1'b1;
                           bus_addr <= r_ptr;
                        end else begin
                           r_state <= c_REG;
                        end
                     end
                  end
               end
               c_REG: begin
                  if (rx_valid) begin
                     r_ptr   <= rx_data[ADDR_BITS-1:0];
                     r_state <= c_WAIT_RS;
                  end
               end
               c_FETCH: begin
                  r_state <= c_CAPTURE;
               end
               c_CAPTURE: begin
                  tx_data  <= 8'(bus_rdata);
                  tx_valid <= 1'b1;
                  r_state  <= c_PRESENT;
               end
               c_PRESENT: begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     r_state  <= c_WAIT_ACK;
                  end
               end
               c_WAIT_ACK: begin
                  if (ack_valid) begin
                     if (master_ack) begin
                        r_ptr    <= w_ptr_inc;
                        bus_addr <= w_ptr_inc;
                        bus_r_en <= 1'b1;
                        r_state  <= c_FETCH;
                     end else begin
                        read_done <= 1'b1;
                        r_state   <= c_DRAIN;
                     end
                  end
               end
               default: begin
                  r_state  <= c_IDLE;
                  tx_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
